// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-subset decode stage: opcodes, functs,
// ALU operation codes and the control bundle carried into EX.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int RA_REG_DEFAULT = 31;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_LUI = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_kind_e;
  typedef enum logic [1:0] {DEST_RT, DEST_RD, DEST_RA, DEST_NONE} dest_kind_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch_eq;
    logic       branch_ne;
    logic       jal;
    logic       jr;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_control_decode.sv
// Combinational main decoder: opcode/funct to control bundle, immediate and
// destination selection, rt usage and illegal-instruction flag.
module mips_control_decode
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output ctrl_t       ctrl,
  output imm_kind_e   imm_kind,
  output dest_kind_e  dest_kind,
  output logic        uses_rt,
  output logic        is_jump,
  output logic        illegal
);

  always_comb begin
    ctrl      = '0;
    imm_kind  = IMM_SEXT;
    dest_kind = DEST_RT;
    uses_rt   = 1'b0;
    is_jump   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest_kind      = DEST_RD;
        uses_rt        = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD: ctrl.alu_op = ALU_ADD;
          FN_SUB: ctrl.alu_op = ALU_SUB;
          FN_AND: ctrl.alu_op = ALU_AND;
          FN_OR:  ctrl.alu_op = ALU_OR;
          FN_SLT: ctrl.alu_op = ALU_SLT;
          FN_SLL: ctrl.alu_op = ALU_SLL;
          FN_SRL: ctrl.alu_op = ALU_SRL;
          FN_JR: begin
            ctrl.reg_write = 1'b0;
            ctrl.jr        = 1'b1;
          end
          default: begin
            ctrl.reg_write = 1'b0;
            illegal        = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch_eq = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        uses_rt        = 1'b1;
      end
      OP_BNE: begin
        ctrl.branch_ne = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        uses_rt        = 1'b1;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_AND;
        imm_kind       = IMM_ZEXT;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OR;
        imm_kind       = IMM_ZEXT;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_SLT;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_LUI;
        imm_kind       = IMM_LUI;
      end
      OP_J: begin
        is_jump   = 1'b1;
        dest_kind = DEST_NONE;
      end
      OP_JAL: begin
        is_jump        = 1'b1;
        ctrl.jal       = 1'b1;
        ctrl.reg_write = 1'b1;
        dest_kind      = DEST_RA;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_decoder.sv
// Decode stage: IF/ID register, load-use hazard detection, J/JAL redirect
// and the ID/EX pipeline register feeding EX.
module id_stage_decoder
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int RA_REG = RA_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc_plus1,
  input  logic              flush,
  output logic              stall,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc_plus1,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest,
  output logic [REG_AW-1:0] ex_shamt,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_branch_eq,
  output logic              ex_branch_ne,
  output logic              ex_jal,
  output logic              ex_jr,
  output logic [3:0]        ex_alu_op,
  output logic              err_illegal
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc1;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] shamt;
    ctrl_t             ctrl;
  } id_ex_t;

  logic [DATA_W-1:0] id_instr_reg;
  logic [DATA_W-1:0] id_pc1_reg;
  logic              id_valid_reg;
  id_ex_t            idex_reg;
  id_ex_t            idex_next;

  ctrl_t             ctrl;
  imm_kind_e         imm_kind;
  dest_kind_e        dest_kind;
  logic              uses_rt;
  logic              is_jump;
  logic              illegal;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [15:0]       imm16;
  logic [REG_AW-1:0] dest;
  logic [DATA_W-1:0] imm;
  logic              issue;

  assign rs    = id_instr_reg[25:21];
  assign rt    = id_instr_reg[20:16];
  assign rd    = id_instr_reg[15:11];
  assign imm16 = id_instr_reg[15:0];

  mips_control_decode u_decode (
    .opcode    (id_instr_reg[31:26]),
    .funct     (id_instr_reg[5:0]),
    .ctrl      (ctrl),
    .imm_kind  (imm_kind),
    .dest_kind (dest_kind),
    .uses_rt   (uses_rt),
    .is_jump   (is_jump),
    .illegal   (illegal)
  );

  always_comb begin
    case (dest_kind)
      DEST_RD:   dest = rd;
      DEST_RA:   dest = REG_AW'(RA_REG);
      DEST_NONE: dest = '0;
      default:   dest = rt;
    endcase
  end

  always_comb begin
    case (imm_kind)
      IMM_ZEXT: imm = {{(DATA_W-16){1'b0}}, imm16};
      IMM_LUI:  imm = {imm16, {(DATA_W-16){1'b0}}};
      default:  imm = {{(DATA_W-16){imm16[15]}}, imm16};
    endcase
  end

  // A load in EX whose result feeds this instruction holds it in ID one cycle.
  assign stall = ~flush & id_valid_reg & idex_reg.valid & idex_reg.ctrl.mem_read &
                 (idex_reg.dest != '0) &
                 ((idex_reg.dest == rs) | (uses_rt & (idex_reg.dest == rt)));

  assign redirect    = id_valid_reg & is_jump & ~stall & ~flush;
  assign redirect_pc = {id_pc1_reg[DATA_W-1:26], id_instr_reg[25:0]};
  assign rf_ra1      = rs;
  assign rf_ra2      = rt;
  assign issue       = id_valid_reg & ~flush & ~stall & ~illegal;

  always_comb begin
    idex_next = '0;
    if (issue) begin
      idex_next.valid          = 1'b1;
      idex_next.pc1            = id_pc1_reg;
      idex_next.rd1            = rf_rd1;
      idex_next.rd2            = rf_rd2;
      idex_next.imm            = imm;
      idex_next.rs             = rs;
      idex_next.rt             = rt;
      idex_next.dest           = dest;
      idex_next.shamt          = id_instr_reg[10:6];
      idex_next.ctrl           = ctrl;
      idex_next.ctrl.reg_write = ctrl.reg_write & (dest != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr_reg <= '0;
      id_pc1_reg   <= '0;
      id_valid_reg <= 1'b0;
    end else if (flush || redirect) begin
      id_valid_reg <= 1'b0;
    end else if (!stall) begin
      id_instr_reg <= if_instr;
      id_pc1_reg   <= if_pc_plus1;
      id_valid_reg <= if_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_reg    <= '0;
      err_illegal <= 1'b0;
    end else begin
      idex_reg    <= idex_next;
      err_illegal <= id_valid_reg & illegal & ~flush & ~stall;
    end
  end

  assign ex_valid      = idex_reg.valid;
  assign ex_pc_plus1   = idex_reg.pc1;
  assign ex_rd1        = idex_reg.rd1;
  assign ex_rd2        = idex_reg.rd2;
  assign ex_imm        = idex_reg.imm;
  assign ex_rs         = idex_reg.rs;
  assign ex_rt         = idex_reg.rt;
  assign ex_dest       = idex_reg.dest;
  assign ex_shamt      = idex_reg.shamt;
  assign ex_reg_write  = idex_reg.ctrl.reg_write;
  assign ex_mem_read   = idex_reg.ctrl.mem_read;
  assign ex_mem_write  = idex_reg.ctrl.mem_write;
  assign ex_mem_to_reg = idex_reg.ctrl.mem_to_reg;
  assign ex_alu_src    = idex_reg.ctrl.alu_src;
  assign ex_branch_eq  = idex_reg.ctrl.branch_eq;
  assign ex_branch_ne  = idex_reg.ctrl.branch_ne;
  assign ex_jal        = idex_reg.ctrl.jal;
  assign ex_jr         = idex_reg.ctrl.jr;
  assign ex_alu_op     = idex_reg.ctrl.alu_op;

endmodule

// File: tb/tb_id_stage_decoder.sv
// Bench for id_stage_decoder: directed pipeline scenarios followed by random
// instruction streams, checked against a table-driven instruction model.
module tb_id_stage_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus1;
  logic        flush;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        ex_valid;
  logic [31:0] ex_pc_plus1, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest, ex_shamt;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic        ex_branch_eq, ex_branch_ne, ex_jal, ex_jr;
  logic [3:0]  ex_alu_op;
  logic        err_illegal;

  id_stage_decoder dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc_plus1(if_pc_plus1), .flush(flush), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .ex_valid(ex_valid), .ex_pc_plus1(ex_pc_plus1),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_shamt(ex_shamt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
    .ex_jal(ex_jal), .ex_jr(ex_jr), .ex_alu_op(ex_alu_op), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef enum logic [4:0] {
    M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_JR,
    M_LW, M_SW, M_BEQ, M_BNE, M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LUI, M_J, M_JAL,
    M_ILL
  } mn_e;
  localparam int NLEGAL = 19;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc1, rd1, rd2, imm;
    logic [4:0]  rs, rt, dest, shamt;
    logic        rw, mr, mw, m2r, asrc, beq, bne, jal, jr;
    logic [3:0]  alu;
  } ex_t;

  typedef struct packed {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc1;
  } ifid_t;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  int stall_seen = 0;
  bit rand_mode = 0;
  logic [31:0] pc_ctr = 32'h100;

  ifid_t cur;
  ifid_t prog_q[$];
  ifid_t m_id;
  ex_t   m_ex;
  logic  m_err;
  bit    m_stall, m_redir;
  logic  obs_stall, obs_redir;
  logic [31:0] obs_rpc;

  function automatic bit is_r(mn_e m);
    return m <= M_JR;
  endfunction

  function automatic logic [5:0] op_of(mn_e m);
    case (m)
      M_LW:   return 6'h23;
      M_SW:   return 6'h2B;
      M_BEQ:  return 6'h04;
      M_BNE:  return 6'h05;
      M_ADDI: return 6'h08;
      M_ANDI: return 6'h0C;
      M_ORI:  return 6'h0D;
      M_SLTI: return 6'h0A;
      M_LUI:  return 6'h0F;
      M_J:    return 6'h02;
      M_JAL:  return 6'h03;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] fn_of(mn_e m);
    case (m)
      M_ADD: return 6'h20;
      M_SUB: return 6'h22;
      M_AND: return 6'h24;
      M_OR:  return 6'h25;
      M_SLT: return 6'h2A;
      M_SRL: return 6'h02;
      M_JR:  return 6'h08;
      default: return 6'h00;
    endcase
  endfunction

  // Look the word up in the instruction table; anything not found is illegal.
  function automatic mn_e classify(logic [31:0] w);
    for (int k = 0; k < NLEGAL; k++) begin
      if (op_of(mn_e'(k)) == w[31:26] && (!is_r(mn_e'(k)) || fn_of(mn_e'(k)) == w[5:0]))
        return mn_e'(k);
    end
    return M_ILL;
  endfunction

  function automatic logic [31:0] enc(mn_e m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                      logic [4:0] sh, logic [15:0] imm);
    if (is_r(m)) return {6'h00, rs, rt, rd, sh, fn_of(m)};
    return {op_of(m), rs, rt, imm};
  endfunction

  function automatic ex_t ref_ex(logic [31:0] w, logic [31:0] pc1, logic [31:0] r1, logic [31:0] r2);
    ex_t e;
    mn_e m;
    logic [15:0] i16;
    m = classify(w);
    i16 = w[15:0];
    e = '0;
    e.valid = 1'b1;
    e.pc1 = pc1;
    e.rd1 = r1;
    e.rd2 = r2;
    e.rs = w[25:21];
    e.rt = w[20:16];
    e.shamt = w[10:6];
    if (m inside {M_ANDI, M_ORI}) e.imm = {16'h0000, i16};
    else if (m == M_LUI)          e.imm = {i16, 16'h0000};
    else                          e.imm = {{16{i16[15]}}, i16};
    if (is_r(m))         e.dest = w[15:11];
    else if (m == M_JAL) e.dest = 5'd31;
    else if (m == M_J)   e.dest = 5'd0;
    else                 e.dest = w[20:16];
    e.rw = (m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_LW,
                      M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LUI, M_JAL}) && (e.dest != 5'd0);
    e.mr = (m == M_LW);
    e.m2r = (m == M_LW);
    e.mw = (m == M_SW);
    e.asrc = m inside {M_LW, M_SW, M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LUI};
    e.beq = (m == M_BEQ);
    e.bne = (m == M_BNE);
    e.jal = (m == M_JAL);
    e.jr = (m == M_JR);
    case (m)
      M_SUB, M_BEQ, M_BNE: e.alu = 4'd1;
      M_AND, M_ANDI:       e.alu = 4'd2;
      M_OR, M_ORI:         e.alu = 4'd3;
      M_SLT, M_SLTI:       e.alu = 4'd4;
      M_SLL:               e.alu = 4'd5;
      M_SRL:               e.alu = 4'd6;
      M_LUI:               e.alu = 4'd7;
      default:             e.alu = 4'd0;
    endcase
    return e;
  endfunction

  function automatic ex_t dut_ex();
    ex_t e;
    e.valid = ex_valid; e.pc1 = ex_pc_plus1; e.rd1 = ex_rd1; e.rd2 = ex_rd2; e.imm = ex_imm;
    e.rs = ex_rs; e.rt = ex_rt; e.dest = ex_dest; e.shamt = ex_shamt;
    e.rw = ex_reg_write; e.mr = ex_mem_read; e.mw = ex_mem_write; e.m2r = ex_mem_to_reg;
    e.asrc = ex_alu_src; e.beq = ex_branch_eq; e.bne = ex_branch_ne; e.jal = ex_jal;
    e.jr = ex_jr; e.alu = ex_alu_op;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    mn_e m;
    if ($urandom_range(0, 9) == 0) return $urandom();
    m = mn_e'($urandom_range(0, NLEGAL - 1));
    return enc(m, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 31)), 16'($urandom()));
  endfunction

  function automatic void next_fetch();
    if (prog_q.size() > 0) begin
      cur = prog_q.pop_front();
    end else if (rand_mode) begin
      cur.v = ($urandom_range(0, 99) < 85);
      cur.ins = rand_instr();
      pc_ctr = pc_ctr + 32'd1;
      cur.pc1 = pc_ctr;
    end else begin
      cur = '0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input ex_t obs, input ex_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [31:0] ins, input logic [31:0] pc1);
    ifid_t f;
    f.v = 1'b1;
    f.ins = ins;
    f.pc1 = pc1;
    prog_q.push_back(f);
  endtask

  // One clock of fetch + model: drive, check combinational outputs at the
  // falling edge, advance the model at the rising edge, then check registers.
  task automatic step(input bit fl, input logic [31:0] r1, input logic [31:0] r2);
    mn_e d;
    logic [4:0] rs, rt;
    ex_t nxt;
    flush = fl;
    if_valid = cur.v;
    if_instr = cur.ins;
    if_pc_plus1 = cur.pc1;
    rf_rd1 = r1;
    rf_rd2 = r2;
    @(negedge clk);
    d = classify(m_id.ins);
    rs = m_id.ins[25:21];
    rt = m_id.ins[20:16];
    m_stall = !fl && m_id.v && m_ex.valid && m_ex.mr && (m_ex.dest != 5'd0) &&
              ((m_ex.dest == rs) ||
               ((is_r(d) || d inside {M_SW, M_BEQ, M_BNE}) && m_ex.dest == rt));
    m_redir = m_id.v && (d == M_J || d == M_JAL) && !m_stall && !fl;
    obs_stall = stall;
    obs_redir = redirect;
    obs_rpc = redirect_pc;
    if (stall === 1'b1) stall_seen++;
    chk("stall", stall, m_stall);
    chk("redirect", redirect, m_redir);
    if (m_redir) chk("redirect_pc", redirect_pc, {m_id.pc1[31:26], m_id.ins[25:0]});
    if (m_id.v) begin
      chk("rf_ra1", rf_ra1, rs);
      chk("rf_ra2", rf_ra2, rt);
    end
    @(posedge clk);
    if (fl || m_stall || !m_id.v || d == M_ILL) nxt = '0;
    else nxt = ref_ex(m_id.ins, m_id.pc1, r1, r2);
    m_err = m_id.v && (d == M_ILL) && !fl && !m_stall;
    if (fl || m_redir) m_id.v = 1'b0;
    else if (!m_stall) m_id = cur;
    m_ex = nxt;
    #1;
    chk_ex("id_ex", dut_ex(), m_ex);
    chk("err_illegal", err_illegal, m_err);
    step_no++;
    $display("step %0d flush=%0b fetch=%h/%0b stall=%0b redirect=%0b ex_valid=%0b dest=%0d err=%0b",
             step_no, fl, cur.ins, cur.v, obs_stall, obs_redir, ex_valid, ex_dest, err_illegal);
    if (!m_stall) next_fetch();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    if_valid = 1'b0;
    if_instr = '0;
    if_pc_plus1 = '0;
    rf_rd1 = '0;
    rf_rd2 = '0;
    cur = '0;
    m_id = '0;
    m_ex = '0;
    m_err = 1'b0;
    #12;
    chk_ex("reset_ex", dut_ex(), '0);
    chk("reset_stall", stall, 0);
    chk("reset_redirect", redirect, 0);
    chk("reset_err", err_illegal, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step(0, $urandom(), $urandom());

    // add $3,$1,$2
    feed(32'h00221820, 32'h10);
    next_fetch();
    step(0, $urandom(), $urandom());
    step(0, 32'd5, 32'd7);
    chk("add_valid", ex_valid, 1);
    chk("add_alu_op", ex_alu_op, 0);
    chk("add_dest", ex_dest, 3);
    chk("add_reg_write", ex_reg_write, 1);
    chk("add_rd1", ex_rd1, 5);
    chk("add_rd2", ex_rd2, 7);
    chk("add_pc1", ex_pc_plus1, 32'h10);

    // lw $4,8($1); add $5,$4,$2; addi $6,$0,9
    stall_seen = 0;
    feed(32'h8C240008, 32'h20);
    feed(32'h00822820, 32'h21);
    feed(32'h20060009, 32'h22);
    next_fetch();
    step(0, $urandom(), $urandom());
    step(0, $urandom(), $urandom());
    step(0, $urandom(), $urandom());
    chk("lu_stall_obs", obs_stall, 1);
    chk("lu_bubble", ex_valid, 0);
    step(0, $urandom(), $urandom());
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rs", ex_rs, 4);
    chk("lu_add_dest", ex_dest, 5);
    step(0, $urandom(), $urandom());
    chk("lu_held_fetch_dest", ex_dest, 6);
    chk("lu_held_fetch_imm", ex_imm, 9);
    chk("lu_stall_count", stall_seen, 1);

    // Same pair, flushed in the hazard cycle
    feed(32'h8C240008, 32'h30);
    feed(32'h00822820, 32'h31);
    next_fetch();
    step(0, $urandom(), $urandom());
    step(0, $urandom(), $urandom());
    step(1, $urandom(), $urandom());
    chk("flush_stall", obs_stall, 0);
    chk("flush_ex_empty", ex_valid, 0);
    step(0, $urandom(), $urandom());
    chk("flush_id_empty", ex_valid, 0);

    // jal 0x000100 at pc1 0x21, followed by a squashed addi $7,$0,1
    feed(32'h0C000100, 32'h21);
    feed(32'h20070001, 32'h22);
    next_fetch();
    step(0, $urandom(), $urandom());
    step(0, $urandom(), $urandom());
    chk("jal_redirect", obs_redir, 1);
    chk("jal_redirect_pc", obs_rpc, 32'h00000100);
    chk("jal_ex_jal", ex_jal, 1);
    chk("jal_dest", ex_dest, 31);
    chk("jal_pc1", ex_pc_plus1, 32'h21);
    step(0, $urandom(), $urandom());
    chk("jal_squash", ex_valid, 0);

    // Illegal opcode 0x3F, then addi $0,$0,1
    feed(32'hFC000000, 32'h40);
    feed(32'h20000001, 32'h41);
    next_fetch();
    step(0, $urandom(), $urandom());
    step(0, $urandom(), $urandom());
    chk("ill_ex_valid", ex_valid, 0);
    chk("ill_err_pulse", err_illegal, 1);
    step(0, $urandom(), $urandom());
    chk("ill_err_clear", err_illegal, 0);
    chk("addi0_valid", ex_valid, 1);
    chk("addi0_reg_write", ex_reg_write, 0);

    rand_mode = 1;
    next_fetch();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 1'b0;
        #2;
        chk_ex("async_reset_ex", dut_ex(), '0);
        chk("async_reset_err", err_illegal, 0);
        chk("async_reset_redirect", redirect, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_id = '0;
        m_ex = '0;
        m_err = 1'b0;
      end
      step($urandom_range(0, 99) < 8, $urandom(), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_decoder.md
Name: id_stage_decoder

Overview:
- Consumer end of the fetch→decode pipeline interface: owns the IF/ID register, decodes the held instruction and reads the register file.
- Detects load-use hazards and produces the ID/EX pipeline register.
- Issues stall back to fetch and resolves J/JAL redirects in decode.
- Sits between the fetch stage (PC, Plus_One, instruction memory) and the EX stage; word-addressed PC.

Parameters:
- DATA_W, 32, datapath / instruction width
- REG_AW, 5, register-file address width
- RA_REG, 31, link register written by JAL

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents a valid instruction
- if_instr  in  32  fetched instruction
- if_pc_plus1  in  32  address of fetched instruction + 1
- flush  in  1  branch resolved taken in EX; squash ID and ID/EX
- stall  out  1  hold PC and fetch outputs this cycle
- redirect  out  1  J/JAL in ID; fetch loads redirect_pc next edge
- redirect_pc  out  32  {id_pc1[31:26], instr[25:0]}
- rf_ra1  out  5  instr[25:21] (rs) to register file
- rf_ra2  out  5  instr[20:16] (rt) to register file
- rf_rd1  in  32  register-file read data 1, combinational
- rf_rd2  in  32  register-file read data 2, combinational
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc_plus1  out  32  forwarded PC+1 (JAL link value)
- ex_rd1  out  32  latched rf_rd1
- ex_rd2  out  32  latched rf_rd2
- ex_imm  out  32  sign-extended imm; zero-extended for andi/ori; imm<<16 for lui
- ex_rs  out  5  source register numbers, for forwarding
- ex_rt  out  5  source register numbers, for forwarding
- ex_dest  out  5  rd (R-type), rt (I-type), RA_REG (jal)
- ex_shamt  out  5  instr[10:6]
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch_eq, ex_branch_ne, ex_jal, ex_jr  out  1 each  control
- ex_alu_op  out  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 srl, 7 lui-pass
- err_illegal  out  1  one-cycle pulse: illegal instruction dropped

Behaviour:
- Reset (async, rst_n=0): IF/ID instr=0, pc1=0, valid=0; all ex_* = 0; err_illegal=0. Combinational outputs follow from the cleared state: stall=0, redirect=0.
- IF/ID update each rising edge, in priority order:
  - flush or redirect → id_valid←0.
  - stall → hold.
  - else load {if_instr, if_pc_plus1, if_valid}.
- Load-use hazard (combinational):
  - stall = id_valid & ex_valid & ex_mem_read & ex_dest≠0 & (ex_dest==rs | (uses_rt & ex_dest==rt)).
  - uses_rt is true for R-type, sw, beq, bne.
  - stall is forced 0 when flush=1.
- ID/EX update each edge:
  - flush | stall | ~id_valid | illegal → bubble: ex_valid and every control bit 0; data fields don't-care, held at 0.
  - Otherwise latch decode, ex_valid=1.
- Latency: instruction sampled at edge N is in ID during cycle N; it appears on ex_* after edge N+1. A load-use stall adds exactly one cycle.
- Decode (opcode instr[31:26]):
  - 0x00 R-type; funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x00 sll, 0x02 srl, 0x08 jr (ex_jr=1, no reg_write).
  - 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x08 addi, 0x0C andi, 0x0D ori, 0x0A slti, 0x0F lui, 0x02 j, 0x03 jal.
  - Anything else, including an unlisted funct → illegal.
- Register 0: reg_write is cleared whenever dest==0, including R-type to $0. NOP (0x00000000) decodes as sll $0 and becomes a non-writing valid op.
- Redirect:
  - redirect = id_valid & (j|jal) & ~stall & ~flush.
  - On that edge IF/ID is squashed (delay-slot-free).
  - jal passes to EX with ex_jal=1, dest=RA_REG.
  - j passes as a valid no-op (no writes).
- err_illegal is registered; high the cycle after an illegal ID instruction would have advanced.
- Simultaneous events:
  - flush beats stall and redirect.
  - stall beats redirect: the jump waits until the hazard clears.
- Reset mid-operation clears in-flight state immediately; no partial pipeline state survives.

Decomposition:
- Shared package mips_pkg: opcode and funct constants, alu_op encoding, RA_REG, and the id_ex control bundle fields.
- One sub-module, mips_control_decode: purely combinational instr → {control bits, alu_op, imm_kind, uses_rt, illegal}.
- Pipeline registers and hazard logic stay in id_stage_decoder.

Test Plan:
- Reset, then release with if_valid=0 → all ex_*=0, stall=0, redirect=0 for 5 cycles.
- add $3,$1,$2 (0x00221820), pc1=0x10, rf_rd1=5, rf_rd2=7 → two edges later: ex_valid=1, alu_op=0, dest=3, reg_write=1, ex_rd1=5, ex_rd2=7, ex_pc_plus1=0x10.
- lw $4,8($1) then add $5,$4,$2:
  - stall=1 for exactly one cycle while add is in ID.
  - The bubble shows ex_valid=0.
  - Then add issues with rs=4; the fetch input is held and not lost.
- Same lw/add sequence with flush=1 in the stall cycle → stall=0, IF/ID and ID/EX empty next cycle, no spurious issue.
- jal 0x000100 at pc1=0x21:
  - redirect=1, redirect_pc=0x00000100.
  - The following fetched instruction is squashed.
  - EX shows ex_jal=1, dest=31, ex_pc_plus1=0x21.
- Opcode 0x3F, then addi $0,$0,1:
  - Illegal case: ex_valid=0 and err_illegal pulses once.
  - addi case: ex_valid=1 with reg_write=0.
